// File: rtl/cpu_io_responder_if.sv
// Bus bundle between the Z80 core side and the I/O responder.
// Latency: none, signal bundle only.
// Backpressure: WAIT_n stretches the CPU cycle; io_rd/io_wr are held until io_ack.
// Ports (slave = responder view):
//   CPU side   : CEN, M1_n, IORQ, NoRead, Write, A, DO in; DI, DI_valid, WAIT_n, INT_n out
//   Reg block  : io_addr, io_wrdata, io_rd, io_wr out; io_rddata, io_ack in
//   Interrupts : irq, irq_mask, vec_base in; timeout_flag out
interface cpu_io_responder_if #(
    parameter int PORT_BITS = 4
);
    logic                 CEN;
    logic                 M1_n;
    logic                 IORQ;
    logic                 NoRead;
    logic                 Write;
    logic [15:0]          A;
    logic [7:0]           DO;
    logic [7:0]           DI;
    logic                 DI_valid;
    logic                 WAIT_n;
    logic                 INT_n;
    logic [PORT_BITS-1:0] io_addr;
    logic [7:0]           io_wrdata;
    logic                 io_rd;
    logic                 io_wr;
    logic [7:0]           io_rddata;
    logic                 io_ack;
    logic [3:0]           irq;
    logic [3:0]           irq_mask;
    logic [7:0]           vec_base;
    logic                 timeout_flag;

    modport slave (
        input  CEN, M1_n, IORQ, NoRead, Write, A, DO,
        output DI, DI_valid, WAIT_n, INT_n,
        output io_addr, io_wrdata, io_rd, io_wr,
        input  io_rddata, io_ack,
        input  irq, irq_mask, vec_base,
        output timeout_flag
    );

    modport master (
        output CEN, M1_n, IORQ, NoRead, Write, A, DO,
        input  DI, DI_valid, WAIT_n, INT_n,
        input  io_addr, io_wrdata, io_rd, io_wr,
        output io_rddata, io_ack,
        output irq, irq_mask, vec_base,
        input  timeout_flag
    );
endinterface

// File: rtl/cpu_io_responder.sv
// Z80 I/O + interrupt-acknowledge target: decodes a port window, runs req/ack to a register block, supplies IM2 vectors.
// Latency: hit -> io_rd/io_wr next clock; io_ack -> WAIT_n high on the same edge; INT_n registered 1 clock.
// Backpressure: WAIT_n held low while the register block has not acked; io_rd/io_wr held until io_ack.
// Ports: CLK_n (rising edge), RESET_n (sync, active low), bus (cpu_io_responder_if.slave).
// Optional build macro CPU_IO_TIMEOUT_EN: bounds BUSY to TIMEOUT CEN ticks, reads then return 8'hFF
// and timeout_flag sticks until reset. Without it BUSY waits for io_ack forever and timeout_flag is 0.
module cpu_io_responder #(
    parameter logic [7:0] PORT_BASE = 8'hE0,
    parameter int         PORT_BITS = 4,
    parameter logic [7:0] TIMEOUT   = 8'd64
) (
    input  logic              CLK_n,
    input  logic              RESET_n,
    cpu_io_responder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_VEC  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 is_rd;
    logic [PORT_BITS-1:0] addr_q;
    logic [7:0]           wdat_q;
    logic [7:0]           di_q;
    logic                 dv_q;
    logic                 int_n_q;
    logic                 ack_pend;
    logic [7:0]           pend_dat;
    logic                 tmo_flag;

    logic                 win;
    logic                 hit;
    logic                 inta;
    logic                 ack_now;
    logic [7:0]           ack_dat;
    logic                 tmo_hit;
    logic [3:0]           pend;
    logic [7:0]           vec;

    assign win  = (bus.A[7:PORT_BITS] == PORT_BASE[7:PORT_BITS]);
    assign hit  = bus.IORQ && bus.M1_n && win && (bus.Write || !bus.NoRead);
    assign inta = bus.IORQ && !bus.M1_n;

    // An ack seen while CEN was low is parked and consumed on the next CEN tick.
    assign ack_now = bus.io_ack || ack_pend;
    assign ack_dat = ack_pend ? pend_dat : bus.io_rddata;

`ifdef CPU_IO_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == TIMEOUT - 8'd1);
    logic unused_bits;
    assign unused_bits = ^{bus.A[15:8], bus.vec_base[2:0]};
`else
    assign tmo_hit = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{bus.A[15:8], bus.vec_base[2:0], TIMEOUT};
`endif

    // IM2 vector: lowest-numbered pending enabled source wins; 3'b110 when none.
    always_comb begin
        pend = bus.irq & bus.irq_mask;
        vec  = {bus.vec_base[7:3], 3'b110};
        casez (pend)
            4'b???1: vec = {bus.vec_base[7:3], 2'd0, 1'b0};
            4'b??10: vec = {bus.vec_base[7:3], 2'd1, 1'b0};
            4'b?100: vec = {bus.vec_base[7:3], 2'd2, 1'b0};
            4'b1000: vec = {bus.vec_base[7:3], 2'd3, 1'b0};
            default: vec = {bus.vec_base[7:3], 3'b110};
        endcase
    end

    // State register
    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            state <= S_IDLE;
        end else if (bus.CEN) begin
            state <= state_nxt;
        end
    end

    // Next-state logic. In BUSY an ack beats both an abort and a timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (inta) begin
                    state_nxt = S_VEC;
                end else if (hit) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ack_now) begin
                    state_nxt = S_HOLD;
                end else if (!bus.IORQ) begin
                    state_nxt = S_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = S_HOLD;
                end
            end
            S_VEC:   state_nxt = S_HOLD;
            S_HOLD: begin
                if (!bus.IORQ) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            is_rd    <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= 8'h00;
            di_q     <= 8'h00;
            dv_q     <= 1'b0;
            int_n_q  <= 1'b1;
            ack_pend <= 1'b0;
            pend_dat <= 8'h00;
            tmo_flag <= 1'b0;
`ifdef CPU_IO_TIMEOUT_EN
            tmo_cnt  <= 8'd0;
`endif
        end else begin
            // Interrupt merge runs every clock regardless of CEN.
            int_n_q <= ~|(bus.irq & bus.irq_mask);

            if (state == S_BUSY && !bus.CEN && bus.io_ack && !ack_pend) begin
                ack_pend <= 1'b1;
                pend_dat <= bus.io_rddata;
            end else if (state != S_BUSY || bus.CEN) begin
                ack_pend <= 1'b0;
            end

            if (bus.CEN) begin
                case (state)
                    S_IDLE: begin
                        if (inta) begin
                            di_q <= vec;
                            dv_q <= 1'b1;
                        end else if (hit) begin
                            addr_q <= bus.A[PORT_BITS-1:0];
                            wdat_q <= bus.DO;
                            is_rd  <= !bus.Write;
`ifdef CPU_IO_TIMEOUT_EN
                            tmo_cnt <= 8'd0;
`endif
                        end
                    end
                    S_BUSY: begin
                        if (ack_now) begin
                            if (is_rd) begin
                                di_q <= ack_dat;
                                dv_q <= 1'b1;
                            end
                        end else if (bus.IORQ) begin
`ifdef CPU_IO_TIMEOUT_EN
                            if (tmo_hit) begin
                                tmo_flag <= 1'b1;
                                if (is_rd) begin
                                    di_q <= 8'hFF;
                                    dv_q <= 1'b1;
                                end
                            end else begin
                                tmo_cnt <= tmo_cnt + 8'd1;
                            end
`endif
                        end
                    end
                    S_HOLD: begin
                        if (!bus.IORQ) begin
                            dv_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs: request/wait are pure functions of state, data comes from registers.
    always_comb begin
        bus.WAIT_n       = (state != S_BUSY);
        bus.io_rd        = (state == S_BUSY) && is_rd;
        bus.io_wr        = (state == S_BUSY) && !is_rd;
        bus.io_addr      = addr_q;
        bus.io_wrdata    = wdat_q;
        bus.DI           = di_q;
        bus.DI_valid     = dv_q;
        bus.INT_n        = int_n_q;
        bus.timeout_flag = tmo_flag;
    end

endmodule

// File: tb/tb_cpu_io_responder.sv
// Randomized and directed bench for cpu_io_responder against a behavioural model of the port window and IM2 vector.
// Latency expectations: request on the clock after a hit, WAIT_n released on the ack edge.
// Backpressure: io_ack timing is randomized and also delivered while CEN is low.
module tb_cpu_io_responder;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    cpu_io_responder_if #(.PORT_BITS(4)) bus ();

    cpu_io_responder #(
        .PORT_BASE(8'hE0),
        .PORT_BITS(4),
        .TIMEOUT  (8'd64)
    ) dut (
        .CLK_n  (clk),
        .RESET_n(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: window hit from port arithmetic, vector from priority search.
    function automatic bit exp_hit(input logic [7:0] port, input logic wr, input logic noread);
        return ((port / 16) == (8'hE0 / 16)) && (wr || !noread);
    endfunction

    function automatic logic [7:0] exp_vec(input logic [3:0] irq, input logic [3:0] mask, input logic [7:0] base);
        logic [3:0] p;
        p = irq & mask;
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return (base & 8'hF8) | 8'(i * 2);
        end
        return (base & 8'hF8) | 8'h06;
    endfunction

    task automatic bus_idle();
        bus.IORQ = 1'b0; bus.M1_n = 1'b1; bus.Write = 1'b0; bus.NoRead = 1'b0;
        bus.io_ack = 1'b0;
    endtask

    task automatic start_io(input logic [7:0] port, input logic wr, input logic noread, input logic [7:0] wdat);
        logic [7:0] hi;
        hi = 8'($urandom_range(0, 255));
        bus.A = {hi, port}; bus.Write = wr; bus.NoRead = noread; bus.DO = wdat;
        bus.M1_n = 1'b1; bus.IORQ = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        bus.CEN = 1'b1; bus.A = 16'h0000; bus.DO = 8'h00; bus.io_rddata = 8'h00;
        bus.irq = 4'h0; bus.irq_mask = 4'h0; bus.vec_base = 8'h00;
        repeat (3) tick();
        total_cnt++; if (bus.DI !== 8'h00) $display("FAIL reset_DI got=%h exp=00", bus.DI); else pass_cnt++;
        total_cnt++; if (bus.DI_valid !== 1'b0) $display("FAIL reset_DI_valid got=%b exp=0", bus.DI_valid); else pass_cnt++;
        total_cnt++; if (bus.WAIT_n !== 1'b1) $display("FAIL reset_WAIT_n got=%b exp=1", bus.WAIT_n); else pass_cnt++;
        total_cnt++; if (bus.INT_n !== 1'b1) $display("FAIL reset_INT_n got=%b exp=1", bus.INT_n); else pass_cnt++;
        total_cnt++; if ({bus.io_rd, bus.io_wr} !== 2'b00) $display("FAIL reset_req got=%b%b exp=00", bus.io_rd, bus.io_wr); else pass_cnt++;
        total_cnt++; if ({bus.io_addr, bus.io_wrdata} !== 12'h000) $display("FAIL reset_addr_wdat got=%h/%h exp=0/00", bus.io_addr, bus.io_wrdata); else pass_cnt++;
        total_cnt++; if (bus.timeout_flag !== 1'b0) $display("FAIL reset_tmo_flag got=%b exp=0", bus.timeout_flag); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    // One complete I/O cycle with io_ack sampled dly clocks after the hit edge.
    task automatic test_io(input logic [7:0] port, input logic wr, input logic noread,
                           input logic [7:0] wdat, input logic [7:0] rdat, input int dly);
        bit h;
        int low;
        h = exp_hit(port, wr, noread);
        start_io(port, wr, noread, wdat);
        tick();
        if (!h) begin
            repeat (2) tick();
            total_cnt++; if ({bus.io_rd, bus.io_wr, bus.WAIT_n, bus.DI_valid} !== 4'b0010)
                $display("FAIL miss_%h rd/wr/wait/dv got=%b%b%b%b exp=0010", port, bus.io_rd, bus.io_wr, bus.WAIT_n, bus.DI_valid);
            else pass_cnt++;
            bus_idle();
            tick();
            return;
        end
        total_cnt++; if ({bus.io_rd, bus.io_wr} !== {!wr, wr}) $display("FAIL req_%h got=%b%b exp=%b%b", port, bus.io_rd, bus.io_wr, !wr, wr); else pass_cnt++;
        total_cnt++; if (bus.io_addr !== port[3:0]) $display("FAIL io_addr_%h got=%h exp=%h", port, bus.io_addr, port[3:0]); else pass_cnt++;
        if (wr) begin
            total_cnt++; if (bus.io_wrdata !== wdat) $display("FAIL io_wrdata_%h got=%h exp=%h", port, bus.io_wrdata, wdat); else pass_cnt++;
        end
        low = 0;
        for (int i = 0; i < dly; i++) begin
            if (bus.WAIT_n === 1'b0) low++;
            if (i == dly - 1) begin bus.io_ack = 1'b1; bus.io_rddata = rdat; end
            tick();
        end
        bus.io_ack = 1'b0;
        bus.io_rddata = 8'($urandom_range(0, 255));
        total_cnt++; if (low != dly) $display("FAIL wait_len_%h got=%0d exp=%0d", port, low, dly); else pass_cnt++;
        total_cnt++; if ({bus.WAIT_n, bus.io_rd, bus.io_wr, bus.DI_valid} !== {3'b100, !wr})
            $display("FAIL ack_%h wait/rd/wr/dv got=%b%b%b%b exp=100%b", port, bus.WAIT_n, bus.io_rd, bus.io_wr, bus.DI_valid, !wr);
        else pass_cnt++;
        repeat (2) tick();
        if (!wr) begin
            total_cnt++; if (bus.DI !== rdat || bus.DI_valid !== 1'b1) $display("FAIL hold_DI_%h got=%h/%b exp=%h/1", port, bus.DI, bus.DI_valid, rdat); else pass_cnt++;
        end
        bus_idle();
        tick();
        total_cnt++; if (bus.DI_valid !== 1'b0) $display("FAIL release_dv_%h got=%b exp=0", port, bus.DI_valid); else pass_cnt++;
    endtask

    task automatic test_random_io();
        for (int n = 0; n < 24; n++) begin
            logic [7:0] port;
            logic wr, nr;
            port = ($urandom_range(0, 1) == 1) ? (8'hE0 | 8'($urandom_range(0, 15))) : 8'($urandom_range(0, 255));
            wr   = 1'($urandom_range(0, 1));
            nr   = wr ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
            test_io(port, wr, nr, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), int'($urandom_range(1, 8)));
        end
    endtask

    task automatic test_inta(input logic [3:0] irq, input logic [3:0] mask, input logic [7:0] base);
        logic [7:0] ev;
        ev = exp_vec(irq, mask, base);
        bus.irq = irq; bus.irq_mask = mask; bus.vec_base = base;
        repeat (2) tick();
        total_cnt++; if (bus.INT_n !== ((irq & mask) == 4'h0)) $display("FAIL INT_n_%h_%h got=%b", irq, mask, bus.INT_n); else pass_cnt++;
        bus.A = 16'($urandom_range(0, 65535)); bus.M1_n = 1'b0; bus.IORQ = 1'b1;
        tick();
        bus.irq = 4'($urandom_range(0, 15));
        total_cnt++; if ({bus.DI, bus.DI_valid, bus.WAIT_n, bus.io_rd} !== {ev, 3'b110})
            $display("FAIL inta_%h_%h DI/dv/wait/rd got=%h/%b%b%b exp=%h/110", irq, mask, bus.DI, bus.DI_valid, bus.WAIT_n, bus.io_rd, ev);
        else pass_cnt++;
        tick();
        total_cnt++; if (bus.DI !== ev || bus.DI_valid !== 1'b1) $display("FAIL inta_hold got=%h/%b exp=%h/1", bus.DI, bus.DI_valid, ev); else pass_cnt++;
        bus_idle();
        tick();
        total_cnt++; if (bus.DI_valid !== 1'b0) $display("FAIL inta_release got=%b exp=0", bus.DI_valid); else pass_cnt++;
        bus.irq = 4'h0;
        tick();
    endtask

    task automatic test_cen_ack();
        start_io(8'hE5, 1'b0, 1'b0, 8'h00);
        tick();
        bus.CEN = 1'b0;
        bus.irq = 4'b0100; bus.irq_mask = 4'b0100;
        tick();
        total_cnt++; if (bus.INT_n !== 1'b0) $display("FAIL int_no_cen got=%b exp=0", bus.INT_n); else pass_cnt++;
        bus.io_ack = 1'b1; bus.io_rddata = 8'h77;
        tick();
        bus.io_ack = 1'b0; bus.io_rddata = 8'h11;
        tick();
        total_cnt++; if ({bus.WAIT_n, bus.io_rd} !== 2'b01) $display("FAIL cen_frozen wait/rd got=%b%b exp=01", bus.WAIT_n, bus.io_rd); else pass_cnt++;
        bus.CEN = 1'b1;
        tick();
        total_cnt++; if ({bus.WAIT_n, bus.DI_valid, bus.DI} !== {2'b11, 8'h77}) $display("FAIL cen_ack wait/dv/DI got=%b%b/%h exp=11/77", bus.WAIT_n, bus.DI_valid, bus.DI); else pass_cnt++;
        bus_idle(); bus.irq = 4'h0;
        repeat (2) tick();
    endtask

    task automatic test_abort();
        start_io(8'hE1, 1'b0, 1'b0, 8'h00);
        repeat (2) tick();
        bus.IORQ = 1'b0;
        tick();
        total_cnt++; if ({bus.io_rd, bus.WAIT_n, bus.DI_valid} !== 3'b010) $display("FAIL abort rd/wait/dv got=%b%b%b exp=010", bus.io_rd, bus.WAIT_n, bus.DI_valid); else pass_cnt++;
        bus.io_ack = 1'b1; bus.io_rddata = 8'h99;
        tick();
        bus.io_ack = 1'b0;
        tick();
        total_cnt++; if (bus.DI_valid !== 1'b0) $display("FAIL stray_ack dv got=%b exp=0", bus.DI_valid); else pass_cnt++;
        test_io(8'hE6, 1'b0, 1'b0, 8'h00, 8'h3D, 2);
    endtask

    task automatic test_back_to_back();
        start_io(8'hE2, 1'b0, 1'b0, 8'h00);
        tick();
        bus.io_ack = 1'b1; bus.io_rddata = 8'hB4;
        tick();
        bus.io_ack = 1'b0;
        bus.A = 16'h00E9;
        repeat (2) tick();
        total_cnt++; if ({bus.io_rd, bus.DI_valid, bus.DI} !== {2'b01, 8'hB4}) $display("FAIL b2b_no_retrigger rd/dv/DI got=%b%b/%h exp=01/b4", bus.io_rd, bus.DI_valid, bus.DI); else pass_cnt++;
        bus.IORQ = 1'b0;
        tick();
        bus.IORQ = 1'b1;
        tick();
        total_cnt++; if ({bus.io_rd, bus.io_addr} !== {1'b1, 4'h9}) $display("FAIL b2b_second rd/addr got=%b/%h exp=1/9", bus.io_rd, bus.io_addr); else pass_cnt++;
        bus.io_ack = 1'b1;
        tick();
        bus_idle();
        repeat (2) tick();
    endtask

    task automatic test_reset_busy();
        bus.irq = 4'h0;
        start_io(8'hE8, 1'b1, 1'b0, 8'h5C);
        repeat (2) tick();
        rst_n = 1'b0; bus.IORQ = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.io_ack = 1'b1; bus.io_rddata = 8'hAA;
        tick();
        bus.io_ack = 1'b0;
        tick();
        total_cnt++; if ({bus.DI, bus.DI_valid, bus.WAIT_n, bus.INT_n, bus.io_rd, bus.io_wr} !== {8'h00, 5'b01100})
            $display("FAIL rst_busy DI/dv/wait/int/rd/wr got=%h/%b%b%b%b%b exp=00/01100", bus.DI, bus.DI_valid, bus.WAIT_n, bus.INT_n, bus.io_rd, bus.io_wr);
        else pass_cnt++;
        total_cnt++; if ({bus.io_addr, bus.io_wrdata, bus.timeout_flag} !== 13'h0) $display("FAIL rst_busy addr/wdat/tmo got=%h/%h/%b", bus.io_addr, bus.io_wrdata, bus.timeout_flag); else pass_cnt++;
        test_io(8'hE0, 1'b0, 1'b0, 8'h00, 8'h6E, 1);
    endtask

    task automatic test_timeout();
        int low;
        start_io(8'hE2, 1'b0, 1'b0, 8'h00);
        tick();
`ifdef CPU_IO_TIMEOUT_EN
        low = 0;
        while (bus.WAIT_n === 1'b0 && low < 300) begin
            low++;
            tick();
        end
        total_cnt++; if (low != 64) $display("FAIL tmo_len got=%0d exp=64", low); else pass_cnt++;
        total_cnt++; if ({bus.DI, bus.DI_valid, bus.timeout_flag, bus.io_rd} !== {8'hFF, 3'b110}) $display("FAIL tmo_read DI/dv/flag/rd got=%h/%b%b%b exp=ff/110", bus.DI, bus.DI_valid, bus.timeout_flag, bus.io_rd); else pass_cnt++;
        bus.io_ack = 1'b1; bus.io_rddata = 8'h12;
        tick();
        bus.io_ack = 1'b0;
        total_cnt++; if (bus.DI !== 8'hFF) $display("FAIL tmo_late_ack DI got=%h exp=ff", bus.DI); else pass_cnt++;
        bus_idle();
        tick();
        total_cnt++; if ({bus.DI_valid, bus.timeout_flag} !== 2'b01) $display("FAIL tmo_sticky dv/flag got=%b%b exp=01", bus.DI_valid, bus.timeout_flag); else pass_cnt++;
`else
        low = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.WAIT_n === 1'b0) low++;
            tick();
        end
        total_cnt++; if (low != 100 || bus.timeout_flag !== 1'b0) $display("FAIL no_tmo low=%0d flag=%b exp=100/0", low, bus.timeout_flag); else pass_cnt++;
        bus.io_ack = 1'b1; bus.io_rddata = 8'h3C;
        tick();
        bus.io_ack = 1'b0;
        total_cnt++; if ({bus.WAIT_n, bus.DI_valid, bus.DI} !== {2'b11, 8'h3C}) $display("FAIL no_tmo_ack wait/dv/DI got=%b%b/%h exp=11/3c", bus.WAIT_n, bus.DI_valid, bus.DI); else pass_cnt++;
        bus_idle();
        tick();
`endif
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_io(8'hE3, 1'b0, 1'b0, 8'h00, 8'h5A, 5);
        test_io(8'hEF, 1'b1, 1'b1, 8'hC7, 8'h00, 3);
        test_io(8'hD0, 1'b0, 1'b0, 8'h00, 8'h00, 1);
        test_random_io();
        test_inta(4'b1010, 4'hF, 8'h40);
        test_inta(4'b1010, 4'h0, 8'h40);
        for (int n = 0; n < 8; n++) begin
            test_inta(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        test_cen_ack();
        test_abort();
        test_back_to_back();
        test_reset_busy();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
